// File: rtl/bcd_subtractor_serial_if.sv
// Start/done handshake and operand/result bus for the digit-serial
// BCD subtractor.
interface bcd_subtractor_serial_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   in1;
    logic [4*DIGITS-1:0]   in2;
    logic                  bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   diff;
    logic                  bout;
    logic                  invalid;

    modport master (
        output start, in1, in2, bin,
        input  busy, done, diff, bout, invalid
    );

    modport slave (
        input  start, in1, in2, bin,
        output busy, done, diff, bout, invalid
    );
endinterface

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial BCD subtractor: in1 - in2 - bin via nine's-complement
// addition, one digit per clock, least significant digit first.
module bcd_subtractor_serial #(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    bcd_subtractor_serial_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            c_q, c_d;
    logic            bad_q, bad_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    diff_q, diff_d;
    logic            bout_q, bout_d;
    logic            inv_q, inv_d;

    logic [4:0]      t;
    logic            carry;
    logic [3:0]      dig;
    logic            dig_bad;
    logic            any_bad;
    logic [W-1:0]    dig_w;
    logic [W-1:0]    res_next;

    always_comb begin
        t        = {1'b0, a_q[3:0]} + (5'd9 - {1'b0, b_q[3:0]})
                 + {4'd0, c_q};
        carry    = (t > 5'd9);
        dig      = carry ? (t[3:0] + 4'd6) : t[3:0];
        dig_bad  = (a_q[3:0] > 4'd9) || (b_q[3:0] > 4'd9);
        any_bad  = bad_q | dig_bad;
        dig_w    = '0;
        dig_w[3:0] = dig;
        // New digit enters at the MSD end; after DIGITS shifts it is aligned.
        res_next = (res_q >> 4) | (dig_w << (W - 4));

        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        c_d     = c_q;
        bad_d   = bad_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;
        inv_d   = inv_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.in1;
                    b_d     = bus.in2;
                    c_d     = ~bus.bin;
                    cnt_d   = '0;
                    bad_d   = 1'b0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = res_next;
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                c_d   = carry;
                bad_d = any_bad;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DIGITS - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    inv_d   = any_bad;
                    diff_d  = any_bad ? '0 : res_next;
                    bout_d  = any_bad ? 1'b0 : ~carry;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            bad_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            c_q     <= c_d;
            bad_q   <= bad_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            inv_q   <= inv_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.diff    = diff_q;
    assign bus.bout    = bout_q;
    assign bus.invalid = inv_q;
endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Bench for bcd_subtractor_serial: directed cases plus random operations
// against an integer-arithmetic reference model.
module tb_bcd_subtractor_serial;
    localparam int D = 4;
    localparam int W = 4 * D;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bcd_subtractor_serial_if #(.DIGITS(D)) bus ();

    bcd_subtractor_serial #(.DIGITS(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  input logic bi,
                                  output logic [W-1:0] d,
                                  output logic bo,
                                  output logic inv);
        int va, vb, v, m, p;
        logic [W-1:0] tmp;
        va = 0; vb = 0; m = 1; inv = 1'b0;
        for (int i = D - 1; i >= 0; i--) begin
            if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) inv = 1'b1;
            va = va * 10 + int'(a[4*i +: 4]);
            vb = vb * 10 + int'(b[4*i +: 4]);
            m  = m * 10;
        end
        v  = va - vb - int'(bi);
        bo = (v < 0);
        if (v < 0) v += m;
        tmp = '0;
        p = v;
        for (int i = 0; i < D; i++) begin
            tmp[4*i +: 4] = 4'(p % 10);
            p = p / 10;
        end
        d = tmp;
        if (inv) begin
            d  = '0;
            bo = 1'b0;
        end
    endfunction

    // Caller is positioned just after a rising edge; the first negedge
    // here may be the previous op's done cycle (back-to-back accept).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bi, input bit poke, input bit chg);
        logic [W-1:0] ed;
        logic eb, ei;
        model(a, b, bi, ed, eb, ei);
        @(negedge clk);
        bus.start = 1'b1;
        bus.in1   = a;
        bus.in2   = b;
        bus.bin   = bi;
        @(posedge clk);
        #1 chk("busy_acc", {31'd0, bus.busy}, 32'd1);
        for (int i = 1; i <= D; i++) begin
            @(negedge clk);
            bus.start = (poke && i == 2);
            if (poke && i == 2) begin
                bus.in1 = W'($urandom);
                bus.in2 = W'($urandom);
            end
            if (chg) begin
                bus.in1 = W'($urandom);
                bus.bin = 1'($urandom);
            end
            @(posedge clk);
            #1;
            if (i < D) begin
                chk("busy_run", {31'd0, bus.busy}, 32'd1);
                chk("done_early", {31'd0, bus.done}, 32'd0);
            end else begin
                chk("done", {31'd0, bus.done}, 32'd1);
                chk("busy_done", {31'd0, bus.busy}, 32'd0);
                chk("diff", {16'd0, bus.diff}, {16'd0, ed});
                chk("bout", {31'd0, bus.bout}, {31'd0, eb});
                chk("invalid", {31'd0, bus.invalid}, {31'd0, ei});
            end
        end
    endtask

    task automatic idle_cycle(input logic [W-1:0] hold);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("done_pulse", {31'd0, bus.done}, 32'd0);
        chk("diff_hold", {16'd0, bus.diff}, {16'd0, hold});
    endtask

    function automatic logic [W-1:0] rnd_bcd(input bit allow_bad);
        logic [W-1:0] r;
        for (int i = 0; i < D; i++) begin
            if (allow_bad && $urandom_range(0, 15) == 0)
                r[4*i +: 4] = 4'($urandom_range(10, 15));
            else
                r[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    initial begin
        logic [W-1:0] ra, rb, ed;
        logic eb, ei;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.start = 1'b0;
        bus.in1   = '0;
        bus.in2   = '0;
        bus.bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_diff", {16'd0, bus.diff}, 32'd0);
        chk("rst_bout", {31'd0, bus.bout}, 32'd0);
        chk("rst_inv", {31'd0, bus.invalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(16'h5321, 16'h1234, 1'b0, 0, 0);
        chk("basic_abs", {16'd0, bus.diff}, 32'h4087);
        idle_cycle(16'h4087);
        run_op(16'h1234, 16'h5321, 1'b0, 0, 0);
        chk("neg_abs", {16'd0, bus.diff}, 32'h5913);
        run_op(16'h0000, 16'h0000, 1'b1, 0, 0);
        chk("neg_bin", {16'd0, bus.diff}, 32'h9999);
        run_op(16'h9999, 16'h0000, 1'b0, 0, 0);
        run_op(16'h1000, 16'h0001, 1'b0, 0, 0);
        chk("ripple", {16'd0, bus.diff}, 32'h0999);
        run_op(16'h12A4, 16'h0001, 1'b0, 0, 0);
        chk("inv_abs", {31'd0, bus.invalid}, 32'd1);
        idle_cycle(16'h0000);
        run_op(16'h0050, 16'h0020, 1'b0, 0, 0);
        chk("inv_clear", {31'd0, bus.invalid}, 32'd0);
        run_op(16'h7777, 16'h2222, 1'b1, 1, 0);
        run_op(16'h4321, 16'h0999, 1'b0, 0, 1);
        idle_cycle(16'h3322);

        // Asynchronous reset two cycles into a run
        @(negedge clk);
        bus.start = 1'b1;
        bus.in1   = 16'h8888;
        bus.in2   = 16'h1111;
        bus.bin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_done", {31'd0, bus.done}, 32'd0);
        chk("arst_diff", {16'd0, bus.diff}, 32'd0);
        chk("arst_bout", {31'd0, bus.bout}, 32'd0);
        chk("arst_inv", {31'd0, bus.invalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (D + 1) begin
            @(posedge clk);
            #1 chk("arst_nodone", {31'd0, bus.done}, 32'd0);
        end
        run_op(16'h5321, 16'h1234, 1'b0, 0, 0);
        chk("post_rst", {16'd0, bus.diff}, 32'h4087);

        for (int n = 0; n < 60; n++) begin
            ra = rnd_bcd(1);
            rb = rnd_bcd(1);
            run_op(ra, rb, 1'($urandom), $urandom_range(0, 3) == 0,
                   $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) begin
                model(ra, rb, 1'b0, ed, eb, ei);
                idle_cycle(bus.invalid ? 16'h0000 : bus.diff);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
